// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg
// Shared definitions for the branch resolve unit and its branch history table:
//   - RISC-V conditional-branch funct3 encodings (including the two reserved codes)
//   - 2-bit saturating counter type used by the BHT and its reset value
//   - bhtNext(): saturating counter step
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bhtCtr_t;

  // Weakly not-taken.
  localparam bhtCtr_t BHT_CTR_RESET = 2'b01;

  // Saturates at 0 and 3 so a long run never wraps the prediction.
  function automatic bhtCtr_t bhtNext(input bhtCtr_t ctr, input logic taken);
    bhtCtr_t res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// branch_bht
// Branch history table of 2-bit saturating counters, indexed by pc[IDX_W+1:2].
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (all counters -> BHT_CTR_RESET)
//   lookupPc            combinational lookup address
//   lookupTaken         prediction for lookupPc (counter >= 2), pre-update value
//   updateEn            write strobe, applied on the rising edge
//   updatePc            address of the resolved branch
//   updateTaken         resolved direction (+1 taken, -1 not taken, saturating)
module branch_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookupPc,
  output logic            lookupTaken,
  input  logic            updateEn,
  input  logic [XLEN-1:0] updatePc,
  input  logic            updateTaken
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bhtCtr_t          ctr [BHT_DEPTH];
  logic [IDX_W-1:0] lookupIdx;
  logic [IDX_W-1:0] updateIdx;
  logic             unusedPcBits;

  assign lookupIdx = lookupPc[IDX_W+1:2];
  assign updateIdx = updatePc[IDX_W+1:2];

  // Instructions are word aligned and the table aliases above the index bits.
  assign unusedPcBits = ^{lookupPc[XLEN-1:IDX_W+2], lookupPc[1:0],
                          updatePc[XLEN-1:IDX_W+2], updatePc[1:0]};

  // Read straight from the array: no write bypass, so a same-cycle update of
  // the looked-up entry is only visible from the next cycle on.
  assign lookupTaken = ctr[lookupIdx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr[i] <= BHT_CTR_RESET;
    end else if (updateEn) begin
      ctr[updateIdx] <= bhtNext(ctr[updateIdx], updateTaken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves RISC-V conditional branches, JAL and JALR one cycle after acceptance,
// flags mispredictions with a single-cycle redirect pulse and trains a BHT.
// Optional feature macro: BRANCH_STATS_EN (adds stat_branches / stat_mispredicts).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                request handshake
//   in_pc, in_rs1, in_rs2, in_imm    request PC, operands, sign-extended offset
//   in_funct3, in_is_jal, in_is_jalr branch condition / jump kind
//   in_pred_taken, in_pred_target    fetch-stage prediction being checked
//   out_valid/out_ready              result handshake
//   out_taken, out_link              resolved direction, pc+4
//   out_illegal, out_misalign        reserved funct3, taken target with bit[1] set
//   redirect_valid, redirect_pc      one-cycle mispredict pulse and correct next PC
//   flush                            kill the held result and any request accepted this cycle
//   pred_pc, pred_taken              combinational BHT lookup for fetch
//   stat_branches, stat_mispredicts  (BRANCH_STATS_EN only) wrapping event counters
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready = !out_valid | out_ready, so a new request may be taken in the
// same cycle the held result drains. While out_valid & !out_ready all out_*
// and redirect_pc are held stable; redirect_valid is asserted only in the first
// cycle a result is visible and never again while it is stalled.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_link,
  output logic            out_illegal,
  output logic            out_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  logic            accept;
  logic            isJump;
  logic            illegal;
  logic            condTrue;
  logic            taken;
  logic            misalign;
  logic            mispredict;
  logic            doRedirect;
  logic            bhtUpdate;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] nextPc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    condTrue = 1'b0;
    case (in_funct3)
      F3_BEQ:  condTrue = (in_rs1 == in_rs2);
      F3_BNE:  condTrue = (in_rs1 != in_rs2);
      F3_BLT:  condTrue = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  condTrue = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: condTrue = (in_rs1 <  in_rs2);
      F3_BGEU: condTrue = (in_rs1 >= in_rs2);
      default: condTrue = 1'b0;
    endcase
  end

  // funct3 is don't-care for jumps; JALR wins when both jump flags are set.
  assign isJump   = in_is_jal || in_is_jalr;
  assign illegal  = !isJump && (in_funct3 == F3_RSV2 || in_funct3 == F3_RSV3);
  assign taken    = isJump || condTrue;

  assign jalrSum  = in_rs1 + in_imm;
  assign link     = in_pc + XLEN'(4);
  assign target   = in_is_jalr ? {jalrSum[XLEN-1:1], 1'b0} : in_pc + in_imm;
  assign nextPc   = taken ? target : link;
  assign misalign = taken && target[1];

  assign mispredict = (taken != in_pred_taken) || (taken && (target != in_pred_target));
  // Faulting results are left to the exception path, not to a fetch redirect.
  assign doRedirect = mispredict && !illegal && !misalign;

  // Training is independent of flush: the direction was really resolved.
  assign bhtUpdate  = accept && !isJump && !illegal;

  branch_bht #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookupPc    (pred_pc),
    .lookupTaken (pred_taken),
    .updateEn    (bhtUpdate),
    .updatePc    (in_pc),
    .updateTaken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_link       <= '0;
      out_illegal    <= 1'b0;
      out_misalign   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // Default low makes the redirect a single pulse even during a stall.
      redirect_valid <= 1'b0;
      if (accept && !flush) begin
        out_valid      <= 1'b1;
        out_taken      <= taken;
        out_link       <= link;
        out_illegal    <= illegal;
        out_misalign   <= misalign;
        redirect_valid <= doRedirect;
        redirect_pc    <= nextPc;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept && !flush) begin
      stat_branches <= stat_branches + 32'd1;
      if (doRedirect) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int EW    = 2 * XLEN + 4;  // {redirect, redirect_pc, taken, illegal, misalign, link}

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [2:0]      in_funct3;
  logic            in_is_jal, in_is_jalr, in_pred_taken;
  logic [XLEN-1:0] in_pred_target;
  logic            out_valid, out_ready, out_taken, out_illegal, out_misalign;
  logic [XLEN-1:0] out_link;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int bht_m[DEPTH];

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_link(out_link), .out_illegal(out_illegal), .out_misalign(out_misalign),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .pred_pc(pred_pc), .pred_taken(pred_taken)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [31:0] pc, rs1, rs2, imm,
                                          input logic [2:0] f3, input logic jal, jalr, pt,
                                          input logic [31:0] ptgt);
    logic c, ill, tk, mis, red;
    logic [31:0] tgt, lnk, rpc;
    c = 1'b0;
    ill = 1'b0;
    if (f3 == 3'd0) c = (rs1 == rs2);
    else if (f3 == 3'd1) c = (rs1 != rs2);
    else if (f3 == 3'd4) c = ($signed(rs1) < $signed(rs2));
    else if (f3 == 3'd5) c = !($signed(rs1) < $signed(rs2));
    else if (f3 == 3'd6) c = (rs1 < rs2);
    else if (f3 == 3'd7) c = !(rs1 < rs2);
    else ill = !(jal || jalr);
    tk  = jal || jalr || c;
    if (jalr) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else tgt = pc + imm;
    lnk = pc + 32'd4;
    mis = tk && tgt[1];
    red = ((tk != pt) || (tk && tgt != ptgt)) && !ill && !mis;
    rpc = tk ? tgt : lnk;
    return {red, rpc, tk, ill, mis, lnk};
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called and returns at posedge+1. Waits a bounded time for acceptance,
  // releasing out_ready after any stalled cycle.
  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                       input logic jal, jalr, pt, input logic [31:0] ptgt, input logic do_flush);
    logic rdy, ok;
    logic [EW-1:0] e;
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_funct3 = f3; in_is_jal = jal; in_is_jalr = jalr; in_pred_taken = pt;
    in_pred_target = ptgt; flush = do_flush;
    ok = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk) rdy = in_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      #1 out_ready = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no acceptance want acceptance pc=%h", pc);
    end else begin
      e = model(pc, rs1, rs2, imm, f3, jal, jalr, pt, ptgt);
      if (!do_flush) exp_q.push_back(e);
      if (!(jal || jalr) && f3 != 3'd2 && f3 != 3'd3) begin
        if (e[XLEN+2] && bht_m[bidx(pc)] < 3) bht_m[bidx(pc)]++;
        if (!e[XLEN+2] && bht_m[bidx(pc)] > 0) bht_m[bidx(pc)]--;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_v = 1'b0, prev_r = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic first;
    if (!rst_n) begin
      prev_v = 1'b0; prev_r = 1'b0;
    end else begin
      first = out_valid && !(prev_v && !prev_r);
      if (first) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got out_valid=1 want no result");
        end else if (redirect_valid !== exp_q[0][EW-1]) begin
          bad++;
          $display("FAIL redirect_first: got %b want %b", redirect_valid, exp_q[0][EW-1]);
        end
      end else begin
        total++;
        if (redirect_valid !== 1'b0) begin
          bad++;
          $display("FAIL redirect_extra: got %b want 0", redirect_valid);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({redirect_pc, out_taken, out_illegal, out_misalign, out_link} !== e[EW-2:0]) begin
          bad++;
          $display("FAIL result: got rpc=%h t=%b i=%b m=%b l=%h want rpc=%h t=%b i=%b m=%b l=%h",
                   redirect_pc, out_taken, out_illegal, out_misalign, out_link,
                   e[EW-2 -: XLEN], e[XLEN+2], e[XLEN+1], e[XLEN], e[XLEN-1:0]);
        end
      end
      prev_v = out_valid; prev_r = out_ready;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_funct3 = '0;
    in_is_jal = 1'b0; in_is_jalr = 1'b0; in_pred_taken = 1'b0; in_pred_target = '0;
    pred_pc = 32'h40;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, redirect_valid, out_taken, out_illegal, out_misalign, out_link, redirect_pc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b r=%b t=%b l=%h rpc=%h want all 0",
               out_valid, redirect_valid, out_taken, out_link, redirect_pc);
    end
    total++;
    if (pred_taken !== 1'b0) begin
      bad++; $display("FAIL reset_bht: got %b want 0", pred_taken);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    drive(32'h100, 32'd5, 32'd5, 32'h20, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if ({out_valid, out_taken, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 1'b1, 32'h120}) begin
      bad++;
      $display("FAIL beq_redirect: got v=%b t=%b r=%b rpc=%h want 1 1 1 00000120",
               out_valid, out_taken, redirect_valid, redirect_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_unsigned();
    logic [31:0] a[3];
    logic [31:0] b[3];
    a[0] = 32'd7;          b[0] = 32'd7;
    a[1] = 32'hFFFF_FFFF;  b[1] = 32'd1;
    a[2] = 32'd9;          b[2] = 32'h8000_0000;
    drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if (out_taken !== 1'b1) begin bad++; $display("FAIL blt_signed: got %b want 1", out_taken); end
    @(posedge clk); #1;
    drive(32'h204, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd6, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if (out_taken !== 1'b0) begin bad++; $display("FAIL bltu_unsigned: got %b want 0", out_taken); end
    @(posedge clk); #1;
    // Every funct3 against equal / signed-negative / sign-boundary operand pairs.
    for (int f = 0; f < 8; f++)
      for (int p = 0; p < 3; p++)
        drive(32'h300 + 32'(f * 16 + p * 4), a[p], b[p], 32'h40, 3'(f), 1'b0, 1'b0,
              1'b1, 32'h300 + 32'(f * 16 + p * 4) + 32'h40, 1'b0);
  endtask

  task automatic test_jumps();
    drive(32'h300, 32'h203, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 32'h202, 1'b0);
    @(negedge clk);
    total++;
    if ({out_taken, redirect_valid, out_link, redirect_pc} !== {1'b1, 1'b0, 32'h304, 32'h202}) begin
      bad++;
      $display("FAIL jalr_match: got t=%b r=%b l=%h rpc=%h want 1 0 00000304 00000202",
               out_taken, redirect_valid, out_link, redirect_pc);
    end
    @(posedge clk); #1;
    // JAL with reserved funct3 is still legal; negative offset.
    drive(32'h1000, 32'h0, 32'h0, 32'hFFFF_FFF8, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    // Both flags high behaves as JALR.
    drive(32'h2000, 32'h500, 32'h0, 32'h11, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if (redirect_pc !== 32'h510) begin bad++; $display("FAIL jal_jalr_both: got %h want 00000510", redirect_pc); end
    @(posedge clk); #1;
    // Wrapping target and link.
    drive(32'hFFFF_FFF0, 32'd1, 32'd1, 32'h20, 3'd0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    // Misaligned taken target: no redirect despite mispredict.
    drive(32'h100, 32'd3, 32'd3, 32'h2, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++;
    if ({out_misalign, redirect_valid} !== 2'b10) begin
      bad++; $display("FAIL misalign: got m=%b r=%b want 1 0", out_misalign, redirect_valid);
    end
    @(posedge clk); #1;
    // Illegal funct3 predicted taken: not taken, illegal, no redirect.
    drive(32'h180, 32'd3, 32'd3, 32'h8, 3'd2, 1'b0, 1'b0, 1'b1, 32'h188, 1'b0);
    @(negedge clk);
    total++;
    if ({out_taken, out_illegal, redirect_valid} !== 3'b010) begin
      bad++; $display("FAIL illegal: got t=%b i=%b r=%b want 0 1 0", out_taken, out_illegal, redirect_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bht();
    logic [0:7] dir;
    test_reset();
    dir = 8'b1111_0000;  // four taken, four not taken
    pred_pc = 32'h40;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      total++;
      if (pred_taken !== (bht_m[bidx(32'h40)] >= 2)) begin
        bad++; $display("FAIL bht_step%0d: got %b want %b", k, pred_taken, bht_m[bidx(32'h40)] >= 2);
      end
      @(posedge clk); #1;
      if (k < 8)
        drive(32'h40, 32'd1, dir[k] ? 32'd1 : 32'd2, 32'h8, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    drive(32'h40, 32'd1, 32'd1, 32'h8, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(32'h40, 32'd1, 32'd1, 32'h8, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    pred_pc = 32'h140;  // aliases index of 0x40
    @(negedge clk);
    total++;
    if (pred_taken !== 1'b1) begin bad++; $display("FAIL bht_alias: got %b want 1", pred_taken); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    out_ready = 1'b0;
    drive(32'h200, 32'd1, 32'd2, 32'h40, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (redirect_valid) pulses++;
      total++;
      if ({out_valid, in_ready, redirect_pc} !== {1'b1, 1'b0, 32'h240}) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b rdy=%b rpc=%h want 1 0 00000240",
                        c, out_valid, in_ready, redirect_pc);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    if (redirect_valid) pulses++;
    @(posedge clk); #1;
    total++;
    if (pulses != 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_flush();
    pred_pc = 32'h80;
    drive(32'h80, 32'd4, 32'd4, 32'h10, 3'd2, 1'b0, 1'b0, 1'b1, 32'h90, 1'b1);
    @(negedge clk);
    total++;
    if ({out_valid, redirect_valid, pred_taken} !== {2'b00, bht_m[bidx(32'h80)] >= 2}) begin
      bad++; $display("FAIL flush_illegal: got v=%b r=%b p=%b want 0 0 %b",
                      out_valid, redirect_valid, pred_taken, bht_m[bidx(32'h80)] >= 2);
    end
    @(posedge clk); #1;
    // Flushed legal branch still trains the table (counter 1 -> 2).
    pred_pc = 32'hC0;
    drive(32'hC0, 32'd4, 32'd4, 32'h10, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    total++;
    if ({out_valid, redirect_valid, pred_taken} !== 3'b001) begin
      bad++; $display("FAIL flush_train: got v=%b r=%b p=%b want 0 0 1", out_valid, redirect_valid, pred_taken);
    end
    @(posedge clk); #1;
    // Flush a result held by back-pressure.
    out_ready = 1'b0;
    drive(32'h10, 32'd4, 32'd4, 32'h10, 3'd0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    total++;
    if ({out_valid, redirect_valid} !== 2'b00) begin
      bad++; $display("FAIL flush_held: got v=%b r=%b want 0 0", out_valid, redirect_valid);
    end
    @(posedge clk); #1 out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, r1, r2, im;
    logic j, jr;
    for (int n = 0; n < 40; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im = $urandom & 32'h0000_0FFE;
      j  = ($urandom_range(0, 9) == 0);
      jr = ($urandom_range(0, 9) == 0);
      out_ready = 1'($urandom_range(0, 1));
      drive(pc, r1, r2, im, 3'($urandom_range(0, 7)), j, jr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? pc + im : $urandom, 1'b0);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(32'h400, 32'd1, 32'd2, 32'h40, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if ({out_valid, redirect_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_mid: got v=%b r=%b want 0 0", out_valid, redirect_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, redirect_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_release: got rdy=%b v=%b r=%b want 1 0 0", in_ready, out_valid, redirect_valid);
    end
    @(posedge clk); #1 out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jumps();
    test_bht();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
